// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_unit
// Description : Pipelined control unit for the WISC-S25 core. It decodes the
//               IF/ID instruction into a control bundle and carries that
//               bundle through the ID/EX, EX/MEM and MEM/WB registers. It
//               also detects load-use hazards, applies global memory stalls
//               and branch flushes, and drains the pipeline on HLT.
//
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               id_instr          - instruction held in IF/ID
//               id_valid          - IF/ID holds a real instruction
//               mem_stall         - data memory busy, freeze everything
//               branch_taken      - branch in ID resolved taken
//               pc_hold           - PC must not update
//               if_id_hold        - IF/ID must not update
//               if_id_flush       - IF/ID loads a bubble
//               id_branch[_reg]   - ID op is B / BR
//               ex_alu_src        - EX uses the immediate
//               ex_imm_sel        - 00 imm4, 01 offset4, 10 imm8
//               mem_write         - MEM-stage SW
//               mem_enable        - MEM-stage LW/SW
//               mem_to_reg        - MEM-stage LW
//               wb_reg_write      - WB writes the register file
//               wb_pcs            - WB data is PC+2
//               wb_rd             - WB destination register
//               halted            - processor halted
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit #(
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 4,
    parameter int HAZARD_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INSTR_W-1:0]    id_instr,
    input  logic                  id_valid,
    input  logic                  mem_stall,
    input  logic                  branch_taken,
    output logic                  pc_hold,
    output logic                  if_id_hold,
    output logic                  if_id_flush,
    output logic                  id_branch,
    output logic                  id_branch_reg,
    output logic                  ex_alu_src,
    output logic [1:0]            ex_imm_sel,
    output logic                  mem_write,
    output logic                  mem_enable,
    output logic                  mem_to_reg,
    output logic                  wb_reg_write,
    output logic                  wb_pcs,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  halted
);

    // ------------------------------------------------------------------------
    // Control bundle produced in ID and held in ID/EX
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic                  regWrite;
        logic                  aluSrc;
        logic [1:0]            immSel;
        logic                  memWrite;
        logic                  memEnable;
        logic                  memToReg;
        logic                  pcs;
        logic                  isHalt;
        logic [REG_ADDR_W-1:0] rd;
    } ctrl_t;

    localparam ctrl_t c_BUBBLE = '0;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------------
    logic [3:0]            w_op;
    logic [REG_ADDR_W-1:0] w_rdFld;
    logic [REG_ADDR_W-1:0] w_rsFld;
    logic [REG_ADDR_W-1:0] w_rtFld;

    assign w_op    = id_instr[INSTR_W-1 -: 4];
    assign w_rdFld = id_instr[INSTR_W-5 -: REG_ADDR_W];
    assign w_rsFld = id_instr[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign w_rtFld = id_instr[REG_ADDR_W-1:0];

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic                  r_halted;

    ctrl_t                 r_exBundle;

    logic                  r_memRegWrite;
    logic                  r_memWrite;
    logic                  r_memEnable;
    logic                  r_memToReg;
    logic                  r_memPcs;
    logic                  r_memIsHalt;
    logic [REG_ADDR_W-1:0] r_memRd;

    logic                  r_wbRegWrite;
    logic                  r_wbPcs;
    logic [REG_ADDR_W-1:0] r_wbRd;

    // ------------------------------------------------------------------------
    // ID decode, gated by id_valid. Source usage flags are decoded alongside
    // so the hazard check only compares registers the ID op really reads.
    // ------------------------------------------------------------------------
    ctrl_t w_dec;
    logic  w_rsUsed;    // rs = [7:4]
    logic  w_rtLoUsed;  // rt = [3:0]
    logic  w_rtHiUsed;  // rt = [11:8] (SW data, LLB/LHB read-modify)

    always_comb begin
        w_dec      = c_BUBBLE;
        w_rsUsed   = 1'b0;
        w_rtLoUsed = 1'b0;
        w_rtHiUsed = 1'b0;
        if (id_valid) begin
            w_dec.regWrite  = ~w_op[3] | (w_op == 4'b1000) | (w_op == 4'b1010)
                            | (w_op == 4'b1011) | (w_op == 4'b1110);
            w_dec.aluSrc    = ((w_op[3:2] == 2'b01) & (w_op != 4'b0111))
                            | (w_op[3:1] == 3'b100) | (w_op[3:1] == 3'b101);
            if (w_op[3:1] == 3'b100) begin
                w_dec.immSel = 2'b01;
            end else if (w_op[3:1] == 3'b101) begin
                w_dec.immSel = 2'b10;
            end else begin
                w_dec.immSel = 2'b00;
            end
            w_dec.memWrite  = (w_op == 4'b1001);
            w_dec.memEnable = (w_op[3:1] == 3'b100);
            w_dec.memToReg  = (w_op == 4'b1000);
            w_dec.pcs       = (w_op == 4'b1110);
            w_dec.isHalt    = (w_op == 4'b1111);
            w_dec.rd        = w_rdFld;

            w_rsUsed   = ~w_op[3] | (w_op[3:1] == 3'b100) | (w_op == 4'b1101);
            w_rtLoUsed = (w_op[3:2] == 2'b00) | (w_op == 4'b0111);
            w_rtHiUsed = (w_op == 4'b1001) | (w_op[3:1] == 3'b101);
        end
    end

    assign id_branch     = id_valid & (w_op == 4'b1100);
    assign id_branch_reg = id_valid & (w_op == 4'b1101);

    // ------------------------------------------------------------------------
    // Load-use detection. When disabled, an external bypass resolves the
    // dependency and the pipeline never stalls for it.
    // ------------------------------------------------------------------------
    logic w_loadUse;

    generate
        if (HAZARD_EN != 0) begin : g_loadUseDetect
            logic w_rdMatch;
            assign w_rdMatch = (w_rsUsed   & (w_rsFld == r_exBundle.rd))
                             | (w_rtLoUsed & (w_rtFld == r_exBundle.rd))
                             | (w_rtHiUsed & (w_rdFld == r_exBundle.rd));
            // r0 is hard-wired zero, so a load into it creates no dependency
            assign w_loadUse = (r_state == S_RUN) & r_exBundle.memToReg
                             & (r_exBundle.rd != '0) & w_rdMatch;
        end else begin : g_loadUseOff
            assign w_loadUse = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Stall / flush / halt control
    // ------------------------------------------------------------------------
    logic  w_haltGo;
    ctrl_t w_exNext;

    // HLT leaves RUN only when it actually advances into ID/EX this cycle
    assign w_haltGo = (r_state == S_RUN) & w_dec.isHalt & ~mem_stall & ~w_loadUse;

    // Anything sitting in ID once HLT has moved on is younger than HLT and
    // must never reach the register file or memory, so it becomes a bubble.
    assign w_exNext = (w_loadUse || (r_state != S_RUN)) ? c_BUBBLE : w_dec;

    assign pc_hold    = mem_stall | w_loadUse | w_haltGo | (r_state != S_RUN);
    assign if_id_hold = mem_stall | w_loadUse | (r_state == S_HALTED);

    // A load-use stall outranks a taken branch; the branch sees ID again
    // next cycle and is flushed then.
    assign if_id_flush = ~mem_stall
                       & ((r_state == S_DRAIN)
                       | ((r_state == S_RUN) & ~w_loadUse & branch_taken & id_valid));

    // ------------------------------------------------------------------------
    // Stage registers: advance together unless memory is busy
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exBundle    <= c_BUBBLE;
            r_memRegWrite <= 1'b0;
            r_memWrite    <= 1'b0;
            r_memEnable   <= 1'b0;
            r_memToReg    <= 1'b0;
            r_memPcs      <= 1'b0;
            r_memIsHalt   <= 1'b0;
            r_memRd       <= '0;
            r_wbRegWrite  <= 1'b0;
            r_wbPcs       <= 1'b0;
            r_wbRd        <= '0;
        end else if (!mem_stall) begin
            r_exBundle    <= w_exNext;

            r_memRegWrite <= r_exBundle.regWrite;
            r_memWrite    <= r_exBundle.memWrite;
            r_memEnable   <= r_exBundle.memEnable;
            r_memToReg    <= r_exBundle.memToReg;
            r_memPcs      <= r_exBundle.pcs;
            r_memIsHalt   <= r_exBundle.isHalt;
            r_memRd       <= r_exBundle.rd;

            r_wbRegWrite  <= r_memRegWrite;
            r_wbPcs       <= r_memPcs;
            r_wbRd        <= r_memRd;
        end
    end

    // ------------------------------------------------------------------------
    // Halt FSM. The FSM enters HALTED on the same edge that moves the halt
    // marker from EX/MEM into MEM/WB, so WB needs no copy of the marker and
    // halted rises exactly when HLT would have reached write-back.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_halted <= 1'b0;
                    if (w_haltGo) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_memIsHalt && !mem_stall) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                S_HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= S_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Per-stage outputs
    // ------------------------------------------------------------------------
    assign ex_alu_src   = r_exBundle.aluSrc;
    assign ex_imm_sel   = r_exBundle.immSel;
    assign mem_write    = r_memWrite;
    assign mem_enable   = r_memEnable;
    assign mem_to_reg   = r_memToReg;
    assign wb_reg_write = r_wbRegWrite;
    assign wb_pcs       = r_wbPcs;
    assign wb_rd        = r_wbRd;
    assign halted       = r_halted;

endmodule
`default_nettype wire

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle WISC-S25 control decoder.
- Decodes the IF/ID instruction and carries the control bundle through registered ID/EX, EX/MEM and MEM/WB stages.
- Detects load-use hazards, applies global memory stalls and branch flushes, and sequences HLT through a drain state machine.
- Sits beside the datapath pipeline registers; the datapath consumes its per-stage outputs.

Parameters:
INSTR_W, 16, instruction width; opcode is always the top 4 bits.
REG_ADDR_W, 4, register specifier width.
HAZARD_EN, 1, 1 = load-use stall insertion enabled; 0 = never stall on load-use (external bypass).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_instr  in  INSTR_W  instruction in the IF/ID register
id_valid  in  1  IF/ID holds a real instruction
mem_stall  in  1  data memory busy; freeze the whole pipeline
branch_taken  in  1  branch resolved taken in ID (flag check external)
pc_hold  out  1  PC must not update
if_id_hold  out  1  IF/ID must not update
if_id_flush  out  1  IF/ID loads a bubble
id_branch  out  1  ID op is B (1100)
id_branch_reg  out  1  ID op is BR (1101)
ex_alu_src  out  1  EX uses immediate
ex_imm_sel  out  2  00 imm4, 01 offset4, 10 imm8
mem_write  out  1  MEM-stage SW
mem_enable  out  1  MEM-stage LW/SW
mem_to_reg  out  1  MEM-stage LW (forwarded to WB)
wb_reg_write  out  1  WB writes register file
wb_pcs  out  1  WB data is PC+2
wb_rd  out  REG_ADDR_W  WB destination
halted  out  1  processor halted

Behaviour:
- Decode (ID, combinational, op = id_instr[15:12]):
  - RegWrite for op[3]=0, 1000, 1010, 1011, 1110.
  - ALUSrc for 01xx (except 0111), 100x, 101x.
  - imm_sel: 00 shifts, 01 100x, 10 101x.
  - MemWrite for 1001; mem_enable for 100x; mem_to_reg for 1000.
  - rd = instr[11:8].
  - Decode gated by id_valid: invalid gives an all-zero bundle.
- Sources used in ID:
  - rs = [7:4] for 0xxx, 100x, 1101.
  - rt = [3:0] for 0000, 0001, 0010, 0011, 0111.
  - rt = [11:8] for 1001, 1010, 1011.
  - No sources for 1100, 1110, 1111.
- Stage registers ID/EX, EX/MEM, MEM/WB hold the bundle plus rd and an is_halt bit; they advance every cycle unless mem_stall.
- Load-use (HAZARD_EN=1):
  - Condition: ID/EX holds LW, its rd equals a used ID source, and rd != 0.
  - Response: insert a bubble into ID/EX and assert pc_hold and if_id_hold for exactly 1 cycle.
- Priority:
  - mem_stall freezes all stage registers and asserts pc_hold and if_id_hold; flush and bubble insertion are suppressed.
  - Otherwise load-use stall applies.
  - Otherwise if_id_flush = branch_taken & id_valid & in RUN.
- Load-use stall and branch_taken in the same cycle: the stall wins; the branch is re-evaluated the next cycle.
- Halt FSM:
  - RUN: HLT (1111) decoded valid in ID and not stalled → DRAIN; pc_hold asserted from this cycle onward.
  - DRAIN: if_id_flush held high; older instructions retire; when is_halt reaches MEM/WB → HALTED.
  - HALTED: halted=1; pc_hold and if_id_hold stay high; only reset leaves this state.
- Instructions behind HLT never write the register file or memory; they are flushed.
- Reset (async, rst_n=0):
  - All stage registers clear to bubble; FSM = RUN.
  - All outputs 0, except outputs derived from id_instr, which follow decode gated by id_valid.
  - Reset mid-DRAIN or in HALTED returns to RUN immediately.
- Latency: a control bundle reaches wb_* exactly 3 un-stalled cycles after ID.

Test Plan:
- ADD 0x0123 then SUB 0x1456: wb_reg_write=1 with wb_rd=1 3 cycles later, then wb_rd=4; no holds asserted.
- LW 0x8120 then ADD 0x0415: pc_hold=if_id_hold=1 for 1 cycle; wb sequence is 1, bubble(reg_write=0), 4.
- Same pair with HAZARD_EN=0, or LW rd=0 (0x8020 then 0x0405): no stall.
- SW 0x9120 in flight with mem_stall held 3 cycles: all wb/mem outputs frozen; mem_write=1 persists; resumes unchanged.
- B 0xC010 with branch_taken=1: if_id_flush=1 one cycle; a simultaneous load-use case gives stall only, flush the next cycle.
- HLT 0xF000 followed by ADD 0x0123: ADD never shows wb_reg_write; halted=1 3 cycles after HLT in ID; rst_n pulse low clears halted asynchronously.
